alu_cmd_seq: RTL and testbench

- Upstream issue stage for the ALU.
- Accepts ALU commands (Op1, Op2, Sel, C_In, Mode) over a valid/ready interface and queues them in a small FIFO.
- Drives one command at a time onto the ALU's combinational inputs, then captures Result/Equal into a registered response port with valid/ready.
- Isolates the ALU from bursty producers and slow consumers.

---
 rtl/alu_cmd_seq_pkg.sv | 35 +++
 rtl/alu_cmd_fifo.sv | 80 ++++++++
 rtl/alu_cmd_seq.sv | 157 +++++++++++++++
 tb/tb_alu_cmd_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_seq_pkg.sv
// Shared types for the ALU command sequencer: operation select, queued command, FSM state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// ALU_OP_W / ALU_RES_W fix the widths of the external ALU. The command struct is
// built on ALU_OP_W, so the sequencer's OP_W parameter must stay equal to it.
package alu_cmd_seq_pkg;

    localparam int ALU_OP_W  = 4;
    localparam int ALU_RES_W = 8;

    // ALU operation select as seen on the ALU's Sel input.
    typedef enum logic [1:0] {
        SEL_ADD = 2'd0,
        SEL_SUB = 2'd1,
        SEL_AND = 2'd2,
        SEL_OR  = 2'd3
    } sel_t;

    // One queued ALU command, exactly the fields driven onto the ALU inputs.
    typedef struct packed {
        logic [ALU_OP_W-1:0] op1;
        logic [ALU_OP_W-1:0] op2;
        sel_t                sel;
        logic                cin;
        logic                mode;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE    = 2'd1,
        WAIT_RSP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous FIFO of alu_cmd_t with registered occupancy.
// Latency: a push is visible at the head one cycle later; pop_dat is the registered head.
// Backpressure: push ignored when full, pop ignored when empty; no push-pop bypass.
//
// Ports: clk/rstb clock and async active-low reset; push_vld/push_dat write side;
// pop_vld/pop_dat read side (pop_dat is the current head); full, empty, level status.
module alu_cmd_fifo
    import alu_cmd_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             push_vld,
    input  alu_cmd_t         push_dat,
    input  logic             pop_vld,
    output alu_cmd_t         pop_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

    alu_cmd_t         mem_q [DEPTH];
    alu_cmd_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign pop_dat = mem_q[rd_ptr_q];

    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_vld && !empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU issue stage: queues commands, drives one at a time onto the ALU, registers its response.
// Latency: push at edge N into an idle empty block -> popped at N+1 -> rsp_valid after N+2.
// Backpressure: cmd_ready = !full (registered state only); rsp_* held until rsp_ready.
//
// Ports: clk/rstb clock and async active-low reset; cmd_* command input with
// cmd_valid/cmd_ready; alu_* registered ALU inputs and alu_result/alu_equal returns;
// rsp_* registered response with rsp_valid/rsp_ready; level FIFO occupancy; busy activity.
module alu_cmd_seq
    import alu_cmd_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OP_W  = ALU_OP_W,
    parameter int RES_W = ALU_RES_W
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [OP_W-1:0]              cmd_op1,
    input  logic [OP_W-1:0]              cmd_op2,
    input  sel_t                         cmd_sel,
    input  logic                         cmd_cin,
    input  logic                         cmd_mode,
    output logic [OP_W-1:0]              alu_op1,
    output logic [OP_W-1:0]              alu_op2,
    output sel_t                         alu_sel,
    output logic                         alu_cin,
    output logic                         alu_mode,
    input  logic [RES_W-1:0]             alu_result,
    input  logic                         alu_equal,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [RES_W-1:0]             rsp_result,
    output logic                         rsp_equal,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         busy
);

    localparam int LVL_W = $clog2(DEPTH + 1);

    seq_state_t       state_q, state_d;
    alu_cmd_t         alu_cmd_q, alu_cmd_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [RES_W-1:0] rsp_res_q, rsp_res_d;
    logic             rsp_eq_q, rsp_eq_d;
    logic             ready_q, ready_d;

    alu_cmd_t         push_dat;
    alu_cmd_t         head_dat;
    logic             push_vld;
    logic             pop_vld;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    // ready_q holds cmd_ready low through reset and for the first edge after release.
    assign cmd_ready = ready_q && !fifo_full;
    assign push_vld  = cmd_valid && cmd_ready;

    always_comb begin
        push_dat      = '0;
        push_dat.op1  = cmd_op1;
        push_dat.op2  = cmd_op2;
        push_dat.sel  = cmd_sel;
        push_dat.cin  = cmd_cin;
        push_dat.mode = cmd_mode;
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .rstb     (rstb),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // alu_cmd_q only changes on a pop so the ALU inputs stay quiet while idle.
    always_comb begin
        state_d   = state_q;
        alu_cmd_d = alu_cmd_q;
        rsp_vld_d = rsp_vld_q;
        rsp_res_d = rsp_res_q;
        rsp_eq_d  = rsp_eq_q;
        ready_d   = 1'b1;
        pop_vld   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_vld   = 1'b1;
                    alu_cmd_d = head_dat;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                // The ALU has had the whole cycle to settle on alu_cmd_q.
                rsp_res_d = alu_result;
                rsp_eq_d  = alu_equal;
                rsp_vld_d = 1'b1;
                state_d   = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_vld_q && rsp_ready) begin
                    rsp_vld_d = 1'b0;
                    if (!fifo_empty) begin
                        pop_vld   = 1'b1;
                        alu_cmd_d = head_dat;
                        state_d   = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            alu_cmd_q <= '0;
            rsp_vld_q <= 1'b0;
            rsp_res_q <= '0;
            rsp_eq_q  <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_cmd_q <= alu_cmd_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_res_q <= rsp_res_d;
            rsp_eq_q  <= rsp_eq_d;
            ready_q   <= ready_d;
        end
    end

    assign alu_op1    = alu_cmd_q.op1;
    assign alu_op2    = alu_cmd_q.op2;
    assign alu_sel    = alu_cmd_q.sel;
    assign alu_cin    = alu_cmd_q.cin;
    assign alu_mode   = alu_cmd_q.mode;

    assign rsp_valid  = rsp_vld_q;
    assign rsp_result = rsp_res_q;
    assign rsp_equal  = rsp_eq_q;

    assign level      = fifo_level;
    assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: bench-side ALU, response scoreboard, directed phases.
// Latency: checks push->rsp_valid of two edges and a 2-cycle drain cadence.
// Backpressure: holds rsp_ready low to fill the FIFO and verify response stability.
`timescale 1ns/1ps
module tb_alu_cmd_seq;
    import alu_cmd_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int OP_W  = 4;
    localparam int RES_W = 8;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rstb;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op1, cmd_op2;
    sel_t             cmd_sel;
    logic             cmd_cin, cmd_mode;
    logic [OP_W-1:0]  alu_op1, alu_op2;
    sel_t             alu_sel;
    logic             alu_cin, alu_mode;
    logic [RES_W-1:0] alu_result;
    logic             alu_equal;
    logic             rsp_valid, rsp_ready;
    logic [RES_W-1:0] rsp_result;
    logic             rsp_equal;
    logic [LVL_W-1:0] level;
    logic             busy;

    int tests = 0;
    int fails = 0;

    always #12.5 clk = ~clk;

    alu_cmd_seq #(.DEPTH(DEPTH), .OP_W(OP_W), .RES_W(RES_W)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op1    (cmd_op1),
        .cmd_op2    (cmd_op2),
        .cmd_sel    (cmd_sel),
        .cmd_cin    (cmd_cin),
        .cmd_mode   (cmd_mode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_sel    (alu_sel),
        .alu_cin    (alu_cin),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .alu_equal  (alu_equal),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_equal  (rsp_equal),
        .level      (level),
        .busy       (busy)
    );

    // Stand-in combinational ALU; returns {equal, result}.
    function automatic logic [RES_W:0] alu_model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                                 input sel_t s, input logic c, input logic m);
        logic [RES_W-1:0] r;
        logic [RES_W-1:0] ea, eb, ec;
        ea = RES_W'(a);
        eb = RES_W'(b);
        ec = RES_W'(c);
        if (!m) begin
            case (s)
                SEL_ADD: r = ea + eb + ec;
                SEL_SUB: r = ea - eb - ec;
                SEL_AND: r = ea & eb;
                default: r = ea | eb;
            endcase
        end else begin
            case (s)
                SEL_ADD: r = {a, b};
                default: r = ea ^ eb;
            endcase
        end
        return {a == b, r};
    endfunction

    assign {alu_equal, alu_result} = alu_model(alu_op1, alu_op2, alu_sel, alu_cin, alu_mode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected responses in acceptance order; reset discards everything.
    logic [RES_W:0] exp_q[$];
    logic           prev_hold = 1'b0;
    logic [RES_W:0] prev_rsp  = '0;
    int             since_rel = 0;
    int             rsp_cnt   = 0;
    bit             in_stream = 1'b0;

    always @(posedge clk) begin
        if (!rstb) since_rel <= 0;
        else if (since_rel < 3) since_rel <= since_rel + 1;
    end

    always @(negedge clk) begin
        if (!rstb) begin
            exp_q.delete();
            prev_hold = 1'b0;
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_level", 32'(level), 0);
            check("rst_cmd_ready", 32'(cmd_ready), 0);
            check("rst_busy", 32'(busy), 0);
        end else begin
            check("busy_vs_outstanding", 32'(busy), 32'(exp_q.size() != 0));
            check("level_le_depth", 32'(level <= LVL_W'(DEPTH)), 1);
            if (since_rel >= 1) check("cmd_ready_vs_level", 32'(cmd_ready), 32'(level != LVL_W'(DEPTH)));
            if (in_stream) check("stream_level_le2", 32'(level <= LVL_W'(2)), 1);
            if (prev_hold) begin
                check("hold_valid", 32'(rsp_valid), 1);
                check("hold_data", 32'({rsp_equal, rsp_result}), 32'(prev_rsp));
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_rsp: got rsp_valid=1 result=0x%0h, expected no response at %0t",
                             rsp_result, $time);
                end else begin
                    check("rsp_data", 32'({rsp_equal, rsp_result}), 32'(exp_q[0]));
                    if (in_stream) check("stream_equal", 32'(rsp_equal), 0);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        rsp_cnt++;
                    end
                end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_equal, rsp_result};
            if (cmd_valid && cmd_ready)
                exp_q.push_back(alu_model(cmd_op1, cmd_op2, cmd_sel, cmd_cin, cmd_mode));
        end
    end

    // All stimulus is driven 1 ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cmd(input int a, input int b, input int s, input int c, input int m);
        cmd_op1  = OP_W'(a);
        cmd_op2  = OP_W'(b);
        cmd_sel  = sel_t'(s[1:0]);
        cmd_cin  = c[0];
        cmd_mode = m[0];
    endtask

    task automatic push_once(input int a, input int b, input int s, input int c, input int m, output bit acc);
        set_cmd(a, b, s, c, m);
        cmd_valid = 1'b1;
        acc = cmd_ready;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic push_wait(input int a, input int b, input int s, input int c, input int m, input int limit);
        int n = 0;
        set_cmd(a, b, s, c, m);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < limit) begin
            tick(1);
            n++;
        end
        check("push_accept", 32'(cmd_ready), 1);
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick(1);
            n++;
        end
        check(name, 32'(busy), 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got no finish, expected finish within 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        bit             acc;
        logic [RES_W:0] held;
        int             cnt0;

        rstb      = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        set_cmd(0, 0, 0, 0, 0);

        // Reset release.
        #100;
        @(negedge clk);
        check("reset_alu_op1", 32'(alu_op1), 0);
        check("reset_cmd_ready_low", 32'(cmd_ready), 0);
        #2 rstb = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(cmd_ready), 1);

        // Single command: 1+1 -> 2, equal.
        rsp_ready = 1'b1;
        push_once(1, 1, 0, 0, 0, acc);
        check("single_accept", 32'(acc), 1);
        check("single_level_after_push", 32'(level), 1);
        check("single_valid_n", 32'(rsp_valid), 0);
        tick(1);
        check("single_valid_n1", 32'(rsp_valid), 0);
        check("single_alu_op1", 32'(alu_op1), 1);
        tick(1);
        check("single_valid_n2", 32'(rsp_valid), 1);
        check("single_result", 32'(rsp_result), 2);
        check("single_equal", 32'(rsp_equal), 1);
        tick(1);
        check("single_valid_after_hs", 32'(rsp_valid), 0);
        check("single_idle", 32'(busy), 0);

        // Fill to full with rsp_ready low.
        rsp_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push_once(k, 3, k % 4, k & 1, (k > 2) ? 1 : 0, acc);
            check("fill_accept", 32'(acc), 1);
        end
        check("fill_level_full", 32'(level), 4);
        check("fill_cmd_ready_low", 32'(cmd_ready), 0);
        check("fill_first_in_alu", 32'(alu_op1), 1);
        check("fill_rsp_valid", 32'(rsp_valid), 1);
        check("fill_first_result", 32'(rsp_result), 32'hFD);
        push_once(6, 6, 0, 0, 0, acc);
        check("fill_cmd6_rejected", 32'(acc), 0);
        check("fill_level_still_full", 32'(level), 4);

        // Back-pressure hold, then drain one response every two cycles.
        held = {rsp_equal, rsp_result};
        tick(10);
        check("bp_valid_held", 32'(rsp_valid), 1);
        check("bp_data_held", 32'({rsp_equal, rsp_result}), 32'(held));
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("drain_gap", 32'(rsp_valid), 0);
            if (i < 4) check("drain_alu_order", 32'(alu_op1), 32'(i + 2));
            tick(1);
            if (i < 4) check("drain_valid", 32'(rsp_valid), 1);
            else       check("drain_done", 32'(rsp_valid), 0);
        end
        check("drain_idle", 32'(busy), 0);
        check("drain_scoreboard_empty", 32'(exp_q.size()), 0);

        // Stream 12 commands; first two back-to-back, then paced so push meets pop.
        cnt0      = rsp_cnt;
        in_stream = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i >= 2) tick(1);
            push_wait(i, 15 - i, i % 4, 0, 0, 20);
        end
        wait_idle("stream_drain_idle", 60);
        in_stream = 1'b0;
        check("stream_rsp_count", 32'(rsp_cnt - cnt0), 12);
        check("stream_scoreboard_empty", 32'(exp_q.size()), 0);

        // Mid-operation reset: DRIVE with three commands still queued.
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_once(k + 3, k, 2, 0, 0, acc);
        end
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        check("midrst_level_before", 32'(level), 3);
        check("midrst_alu_before", 32'(alu_op1), 4);
        check("midrst_valid_before", 32'(rsp_valid), 0);
        rstb = 1'b0;
        #1;
        check("midrst_level", 32'(level), 0);
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        check("midrst_alu_op1", 32'(alu_op1), 0);
        check("midrst_busy", 32'(busy), 0);
        tick(3);
        @(negedge clk);
        #2 rstb = 1'b1;
        rsp_ready = 1'b1;
        cnt0 = rsp_cnt;
        tick(8);
        check("midrst_no_rsp", 32'(rsp_cnt - cnt0), 0);
        check("midrst_idle", 32'(busy), 0);
        push_once(5, 5, 0, 1, 0, acc);
        check("post_rst_accept", 32'(acc), 1);
        begin
            int n = 0;
            while (!rsp_valid && n < 10) begin
                tick(1);
                n++;
            end
        end
        check("post_rst_valid", 32'(rsp_valid), 1);
        check("post_rst_result", 32'(rsp_result), 11);
        check("post_rst_equal", 32'(rsp_equal), 1);
        tick(2);
        check("post_rst_scoreboard_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
